// File: rtl/vx_cache_wrap.sv
// ---------------------------------------------------------------------------
// vx_cache_wrap
//
// Concentrates NUM_REQS core-side request ports onto MEM_PORTS memory ports.
// Core port i belongs to memory port p = i % MEM_PORTS and has local index
// k = i / MEM_PORTS inside that group.
//
// Per memory port:
//   - round-robin arbiter over the G = NUM_REQS/MEM_PORTS local ports
//   - 2-entry request buffer; a granted request shows up on mem_req_* the
//     cycle after it was accepted
//   - the local index k is appended below the core tag so that responses
//     can be routed back purely from the returned tag
// Responses are routed combinationally. A saturating pending-read counter
// plus the buffer occupancy drive busy.
//
// Ports (arrays flattened, port i at slice i):
//   clk, reset                  clock, synchronous active-high reset
//   core_req_*  [NUM_REQS]      core requests (valid/rw/byteen/addr/data/tag, ready)
//   core_rsp_*  [NUM_REQS]      core responses (valid/data/tag, ready)
//   mem_req_*   [MEM_PORTS]     memory requests, tag = {core tag, k}
//   mem_rsp_*   [MEM_PORTS]     memory responses, tag = {core tag, k}
//   busy                        reads outstanding or requests buffered
// ---------------------------------------------------------------------------
module vx_cache_wrap #(
   parameter int NUM_REQS   = 4,
   parameter int MEM_PORTS  = 1,
   parameter int LINE_SIZE  = 64,
   parameter int ADDR_WIDTH = 26,
   parameter int TAG_WIDTH  = 8,
   localparam int G             = NUM_REQS / MEM_PORTS,
   localparam int IW            = (G > 1) ? $clog2(G) : 1,
   localparam int MEM_TAG_WIDTH = TAG_WIDTH + IW,
   localparam int DW            = 8 * LINE_SIZE
) (
   input  logic                               clk,
   input  logic                               reset,

   input  logic [NUM_REQS-1:0]                core_req_valid,
   input  logic [NUM_REQS-1:0]                core_req_rw,
   input  logic [NUM_REQS*LINE_SIZE-1:0]      core_req_byteen,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0]     core_req_addr,
   input  logic [NUM_REQS*DW-1:0]             core_req_data,
   input  logic [NUM_REQS*TAG_WIDTH-1:0]      core_req_tag,
   output logic [NUM_REQS-1:0]                core_req_ready,

   output logic [NUM_REQS-1:0]                core_rsp_valid,
   output logic [NUM_REQS*DW-1:0]             core_rsp_data,
   output logic [NUM_REQS*TAG_WIDTH-1:0]      core_rsp_tag,
   input  logic [NUM_REQS-1:0]                core_rsp_ready,

   output logic [MEM_PORTS-1:0]               mem_req_valid,
   output logic [MEM_PORTS-1:0]               mem_req_rw,
   output logic [MEM_PORTS*LINE_SIZE-1:0]     mem_req_byteen,
   output logic [MEM_PORTS*ADDR_WIDTH-1:0]    mem_req_addr,
   output logic [MEM_PORTS*DW-1:0]            mem_req_data,
   output logic [MEM_PORTS*MEM_TAG_WIDTH-1:0] mem_req_tag,
   input  logic [MEM_PORTS-1:0]               mem_req_ready,

   input  logic [MEM_PORTS-1:0]               mem_rsp_valid,
   input  logic [MEM_PORTS*DW-1:0]            mem_rsp_data,
   input  logic [MEM_PORTS*MEM_TAG_WIDTH-1:0] mem_rsp_tag,
   output logic [MEM_PORTS-1:0]               mem_rsp_ready,

   output logic                               busy
);

   // Buffer entry layout: {rw, byteen, addr, data, mem_tag}
   localparam int EW     = 1 + LINE_SIZE + ADDR_WIDTH + DW + MEM_TAG_WIDTH;
   localparam int OFS_D  = MEM_TAG_WIDTH;
   localparam int OFS_A  = OFS_D + DW;
   localparam int OFS_BE = OFS_A + ADDR_WIDTH;

   localparam int CW = $clog2(NUM_REQS * 4) + 1;

   logic [MEM_PORTS-1:0] rd_fire;
   logic [MEM_PORTS-1:0] rsp_fire;
   logic [MEM_PORTS-1:0] nonempty;

   genvar gi, gj;
   generate
      for (gi = 0; gi < MEM_PORTS; gi++) begin : g_port
         logic [G-1:0]    req_vec;
         logic [EW-1:0]   cand [G];
         logic [G-1:0]    rsp_rdy_sel;
         logic [IW-1:0]   rsp_k;

         logic [IW-1:0]   ptr_reg;
         logic [IW-1:0]   ptr_next;
         logic [IW-1:0]   lo_idx, hi_idx, grant_idx;
         logic            lo_found, hi_found, grant_found;

         logic [1:0]      count_reg;
         logic            wr_ptr_reg, rd_ptr_reg;
         logic [EW-1:0]   buf_reg [2];
         logic [EW-1:0]   head;
         logic            can_accept, push, pop;

         // Local index carried in the low tag bits; absent when G == 1.
         assign rsp_k = (G > 1) ? mem_rsp_tag[gi*MEM_TAG_WIDTH +: IW] : '0;

         for (gj = 0; gj < G; gj++) begin : g_loc
            localparam int I = gi + gj * MEM_PORTS;

            assign req_vec[gj] = core_req_valid[I];
            assign cand[gj] = {core_req_rw[I],
                               core_req_byteen[I*LINE_SIZE +: LINE_SIZE],
                               core_req_addr[I*ADDR_WIDTH +: ADDR_WIDTH],
                               core_req_data[I*DW +: DW],
                               core_req_tag[I*TAG_WIDTH +: TAG_WIDTH],
                               IW'(gj)};
            assign core_req_ready[I] = !reset && can_accept && grant_found
                                       && (grant_idx == IW'(gj));

            assign core_rsp_valid[I] = mem_rsp_valid[gi] && (rsp_k == IW'(gj));
            assign core_rsp_data[I*DW +: DW] = mem_rsp_data[gi*DW +: DW];
            assign core_rsp_tag[I*TAG_WIDTH +: TAG_WIDTH] =
               mem_rsp_tag[gi*MEM_TAG_WIDTH + IW +: TAG_WIDTH];
            assign rsp_rdy_sel[gj] = (rsp_k == IW'(gj)) && core_rsp_ready[I];
         end

         assign mem_rsp_ready[gi] = |rsp_rdy_sel;

         // Round-robin: first requester at or above the pointer wins,
         // otherwise wrap around to the lowest requester.
         always_comb begin
            lo_found = 1'b0;
            hi_found = 1'b0;
            lo_idx   = '0;
            hi_idx   = '0;
            for (int k = 0; k < G; k++) begin
               if (req_vec[k] && !lo_found) begin
                  lo_found = 1'b1;
                  lo_idx   = IW'(k);
               end
               if (req_vec[k] && !hi_found && (IW'(k) >= ptr_reg)) begin
                  hi_found = 1'b1;
                  hi_idx   = IW'(k);
               end
            end
         end

         assign grant_found = lo_found;
         assign grant_idx   = hi_found ? hi_idx : lo_idx;
         assign ptr_next    = (grant_idx == IW'(G - 1)) ? '0 : grant_idx + IW'(1);

         // Accept only into a free slot; with mem_req_ready held high the
         // buffer hovers at one entry, so one request per cycle still flows.
         assign can_accept = (count_reg != 2'd2);
         assign push       = grant_found && can_accept;
         assign pop        = (count_reg != 2'd0) && mem_req_ready[gi];

         always_ff @(posedge clk) begin
            if (reset) begin
               count_reg  <= 2'd0;
               wr_ptr_reg <= 1'b0;
               rd_ptr_reg <= 1'b0;
               ptr_reg    <= '0;
            end else begin
               if (push) begin
                  wr_ptr_reg <= ~wr_ptr_reg;
                  ptr_reg    <= ptr_next;
               end
               if (pop) begin
                  rd_ptr_reg <= ~rd_ptr_reg;
               end
               count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            end
         end

         // Payload storage needs no reset; occupancy alone decides validity.
         always_ff @(posedge clk) begin
            if (push) begin
               buf_reg[wr_ptr_reg] <= cand[grant_idx];
            end
         end

         assign head = buf_reg[rd_ptr_reg];

         assign mem_req_valid[gi] = !reset && (count_reg != 2'd0);
         assign mem_req_rw[gi]    = head[EW-1];
         assign mem_req_byteen[gi*LINE_SIZE +: LINE_SIZE]           = head[OFS_BE +: LINE_SIZE];
         assign mem_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]           = head[OFS_A +: ADDR_WIDTH];
         assign mem_req_data[gi*DW +: DW]                           = head[OFS_D +: DW];
         assign mem_req_tag[gi*MEM_TAG_WIDTH +: MEM_TAG_WIDTH]      = head[0 +: MEM_TAG_WIDTH];

         assign rd_fire[gi]  = mem_req_valid[gi] && mem_req_ready[gi] && !mem_req_rw[gi];
         assign rsp_fire[gi] = mem_rsp_valid[gi] && mem_rsp_ready[gi];
         assign nonempty[gi] = (count_reg != 2'd0);
      end
   endgenerate

   // Pending-read counter: net change per cycle, clamped to [0, max].
   // The floor matters after a reset, when stale responses can still land.
   logic [CW-1:0] pending_reg;
   logic [CW-1:0] pending_next;
   logic [CW+1:0] inc_cnt, dec_cnt, up_sum, net;

   always_comb begin
      inc_cnt = '0;
      dec_cnt = '0;
      for (int p = 0; p < MEM_PORTS; p++) begin
         inc_cnt = inc_cnt + (CW+2)'(rd_fire[p]);
         dec_cnt = dec_cnt + (CW+2)'(rsp_fire[p]);
      end
      up_sum = {2'b00, pending_reg} + inc_cnt;
      net    = up_sum - dec_cnt;
      if (dec_cnt >= up_sum) begin
         pending_next = '0;
      end else if (net > {2'b00, {CW{1'b1}}}) begin
         pending_next = '1;
      end else begin
         pending_next = net[CW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign busy = !reset && ((pending_reg != '0) || (|nonempty));

endmodule

// File: tb/tb_vx_cache_wrap.sv
// ---------------------------------------------------------------------------
// tb_vx_cache_wrap
//
// Directed bench for vx_cache_wrap at NUM_REQS=4, MEM_PORTS=1: reset state,
// single read round trip, round-robin contention, backpressure, write
// forwarding, response stall and reset in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_vx_cache_wrap;
   localparam int NR  = 4;
   localparam int MP  = 1;
   localparam int LS  = 64;
   localparam int AW  = 26;
   localparam int TW  = 8;
   localparam int DW  = 8 * LS;
   localparam int MTW = TW + 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [NR-1:0]       core_req_valid;
   logic [NR-1:0]       core_req_rw;
   logic [NR*LS-1:0]    core_req_byteen;
   logic [NR*AW-1:0]    core_req_addr;
   logic [NR*DW-1:0]    core_req_data;
   logic [NR*TW-1:0]    core_req_tag;
   logic [NR-1:0]       core_req_ready;
   logic [NR-1:0]       core_rsp_valid;
   logic [NR*DW-1:0]    core_rsp_data;
   logic [NR*TW-1:0]    core_rsp_tag;
   logic [NR-1:0]       core_rsp_ready;
   logic [MP-1:0]       mem_req_valid;
   logic [MP-1:0]       mem_req_rw;
   logic [MP*LS-1:0]    mem_req_byteen;
   logic [MP*AW-1:0]    mem_req_addr;
   logic [MP*DW-1:0]    mem_req_data;
   logic [MP*MTW-1:0]   mem_req_tag;
   logic [MP-1:0]       mem_req_ready;
   logic [MP-1:0]       mem_rsp_valid;
   logic [MP*DW-1:0]    mem_rsp_data;
   logic [MP*MTW-1:0]   mem_rsp_tag;
   logic [MP-1:0]       mem_rsp_ready;
   logic                busy;

   int n_cmp = 0;
   int n_bad = 0;

   vx_cache_wrap #(
      .NUM_REQS  (NR),
      .MEM_PORTS (MP),
      .LINE_SIZE (LS),
      .ADDR_WIDTH(AW),
      .TAG_WIDTH (TW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .core_req_valid (core_req_valid),
      .core_req_rw    (core_req_rw),
      .core_req_byteen(core_req_byteen),
      .core_req_addr  (core_req_addr),
      .core_req_data  (core_req_data),
      .core_req_tag   (core_req_tag),
      .core_req_ready (core_req_ready),
      .core_rsp_valid (core_rsp_valid),
      .core_rsp_data  (core_rsp_data),
      .core_rsp_tag   (core_rsp_tag),
      .core_rsp_ready (core_rsp_ready),
      .mem_req_valid  (mem_req_valid),
      .mem_req_rw     (mem_req_rw),
      .mem_req_byteen (mem_req_byteen),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_tag    (mem_req_tag),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_tag    (mem_rsp_tag),
      .mem_rsp_ready  (mem_rsp_ready),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      core_req_valid  = '0;
      core_req_rw     = '0;
      core_req_byteen = '0;
      core_req_addr   = '0;
      core_req_data   = '0;
      core_req_tag    = '0;
      core_rsp_ready  = '1;
      mem_req_ready   = '0;
      mem_rsp_valid   = '0;
      mem_rsp_data    = '0;
      mem_rsp_tag     = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a,
                          input logic [TW-1:0] t, input logic [DW-1:0] d);
      core_req_valid[i]            = 1'b1;
      core_req_rw[i]               = rw;
      core_req_byteen[i*LS +: LS]  = '1;
      core_req_addr[i*AW +: AW]    = a;
      core_req_tag[i*TW +: TW]     = t;
      core_req_data[i*DW +: DW]    = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      core_req_valid = '1;
      mem_rsp_valid  = 1'b1;
      mem_rsp_tag    = {8'h11, 2'b01};
      cyc();
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mem_valid: got %b expected 0", mem_req_valid); end
      n_cmp++; if (core_req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_core_ready: got %b expected 0000", core_req_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_cmp++; if (core_rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL rst_rsp_route: got %b expected 0010", core_rsp_valid); end
      $display("reset: rsp_valid=%b busy=%b", core_rsp_valid, busy);
      cyc();
      do_reset();
   endtask

   task automatic test_single_read();
      logic [DW-1:0] d;
      d = {16{32'hDEADBEEF}};
      do_reset();
      mem_req_ready = 1'b1;
      set_req(2, 1'b0, 26'h100, 8'h5A, '0);
      @(negedge clk);
      n_cmp++; if (core_req_ready !== 4'b0100) begin n_bad++; $display("FAIL sr_grant: got %b expected 0100", core_req_ready); end
      cyc();
      core_req_valid = '0;
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL sr_mem_valid: got %b expected 1", mem_req_valid); end
      n_cmp++; if (mem_req_tag !== 10'h16A) begin n_bad++; $display("FAIL sr_mem_tag: got %h expected 16a", mem_req_tag); end
      n_cmp++; if (mem_req_addr !== 26'h100) begin n_bad++; $display("FAIL sr_mem_addr: got %h expected 100", mem_req_addr); end
      n_cmp++; if (mem_req_rw !== 1'b0) begin n_bad++; $display("FAIL sr_mem_rw: got %b expected 0", mem_req_rw); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sr_busy_buf: got %b expected 1", busy); end
      $display("single read: mem req tag=%h addr=%h", mem_req_tag, mem_req_addr);
      cyc();
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL sr_mem_drain: got %b expected 0", mem_req_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sr_busy_pend: got %b expected 1", busy); end
      cyc();
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 10'h16A;
      mem_rsp_data  = d;
      @(negedge clk);
      n_cmp++; if (core_rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL sr_rsp_valid: got %b expected 0100", core_rsp_valid); end
      n_cmp++; if (core_rsp_data[2*DW +: DW] !== d) begin n_bad++; $display("FAIL sr_rsp_data: got %h expected %h", core_rsp_data[2*DW +: 32], d[31:0]); end
      n_cmp++; if (core_rsp_tag[2*TW +: TW] !== 8'h5A) begin n_bad++; $display("FAIL sr_rsp_tag: got %h expected 5a", core_rsp_tag[2*TW +: TW]); end
      n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_bad++; $display("FAIL sr_rsp_ready: got %b expected 1", mem_rsp_ready); end
      $display("single read: rsp tag=%h on port 2", core_rsp_tag[2*TW +: TW]);
      cyc();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sr_busy_idle: got %b expected 0", busy); end
      cyc();
   endtask

   task automatic test_contention();
      logic [3:0]     exp_rdy;
      logic [MTW-1:0] exp_tag;
      int             k;
      do_reset();
      mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 26'(26'h10 + i), 8'(8'h40 + i), '0);
      for (int c = 0; c < 6; c++) begin
         if (c == 5) core_req_valid = '0;
         @(negedge clk);
         if (c < 5) begin
            exp_rdy = 4'b0001 << (c % 4);
            n_cmp++; if (core_req_ready !== exp_rdy) begin n_bad++; $display("FAIL ct_grant[%0d]: got %b expected %b", c, core_req_ready, exp_rdy); end
         end
         if (c >= 1) begin
            k = (c - 1) % 4;
            exp_tag = {8'(8'h40 + k), 2'(k)};
            n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL ct_mem_valid[%0d]: got %b expected 1", c, mem_req_valid); end
            n_cmp++; if (mem_req_tag !== exp_tag) begin n_bad++; $display("FAIL ct_mem_tag[%0d]: got %h expected %h", c, mem_req_tag, exp_tag); end
         end
         $display("contention cycle %0d: ready=%b mem_tag=%h", c, core_req_ready, mem_req_tag);
         cyc();
      end
   endtask

   task automatic test_backpressure();
      logic [3:0]     exp_rdy [10];
      logic           exp_mv  [10];
      int             exp_hd  [10];
      logic [3:0]     seen;
      logic [MTW-1:0] exp_tag;
      int             n_out;
      exp_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                  4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
      exp_mv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_hd  = '{-1, 0, 0, 0, 0, 0, 1, 2, 3, -1};
      n_out = 0;
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 26'(26'h200 + i), 8'(8'hA0 + i), '0);
      for (int c = 0; c < 10; c++) begin
         mem_req_ready = (c >= 5);
         @(negedge clk);
         n_cmp++; if (core_req_ready !== exp_rdy[c]) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, core_req_ready, exp_rdy[c]); end
         n_cmp++; if (mem_req_valid !== exp_mv[c]) begin n_bad++; $display("FAIL bp_mem_valid[%0d]: got %b expected %b", c, mem_req_valid, exp_mv[c]); end
         if (exp_hd[c] >= 0) begin
            exp_tag = {8'(8'hA0 + exp_hd[c]), 2'(exp_hd[c])};
            n_cmp++; if (mem_req_tag !== exp_tag) begin n_bad++; $display("FAIL bp_head_tag[%0d]: got %h expected %h", c, mem_req_tag, exp_tag); end
         end
         if (mem_req_valid[0] && mem_req_ready[0]) n_out++;
         $display("backpressure cycle %0d: ready=%b mem_valid=%b mem_tag=%h", c, core_req_ready, mem_req_valid, mem_req_tag);
         seen = core_req_ready & core_req_valid;
         cyc();
         core_req_valid = core_req_valid & ~seen;
      end
      n_cmp++; if (n_out !== 4) begin n_bad++; $display("FAIL bp_count: got %0d expected 4", n_out); end
   endtask

   task automatic test_write();
      logic [DW-1:0] d;
      d = {64{8'hAB}};
      do_reset();
      mem_req_ready = 1'b1;
      set_req(1, 1'b1, 26'h2A, 8'h33, d);
      @(negedge clk);
      n_cmp++; if (core_req_ready !== 4'b0010) begin n_bad++; $display("FAIL wr_grant: got %b expected 0010", core_req_ready); end
      cyc();
      core_req_valid = '0;
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL wr_mem_valid: got %b expected 1", mem_req_valid); end
      n_cmp++; if (mem_req_rw !== 1'b1) begin n_bad++; $display("FAIL wr_mem_rw: got %b expected 1", mem_req_rw); end
      n_cmp++; if (mem_req_data !== d) begin n_bad++; $display("FAIL wr_mem_data: got %h expected %h", mem_req_data[31:0], d[31:0]); end
      n_cmp++; if (mem_req_byteen !== {LS{1'b1}}) begin n_bad++; $display("FAIL wr_mem_byteen: got %h expected all ones", mem_req_byteen); end
      n_cmp++; if (mem_req_addr !== 26'h2A) begin n_bad++; $display("FAIL wr_mem_addr: got %h expected 2a", mem_req_addr); end
      n_cmp++; if (mem_req_tag !== 10'h0CD) begin n_bad++; $display("FAIL wr_mem_tag: got %h expected 0cd", mem_req_tag); end
      $display("write: mem rw=%b tag=%h", mem_req_rw, mem_req_tag);
      cyc();
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy: got %b expected 0", busy); end
      n_cmp++; if (core_rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL wr_no_rsp: got %b expected 0000", core_rsp_valid); end
      cyc();
   endtask

   task automatic test_rsp_stall();
      int n_xfer;
      n_xfer = 0;
      do_reset();
      core_rsp_ready = 4'b0111;
      mem_rsp_valid  = 1'b1;
      mem_rsp_tag    = {8'h77, 2'b11};
      mem_rsp_data   = {16{32'h0BADF00D}};
      for (int c = 0; c < 5; c++) begin
         if (c == 2) core_rsp_ready = 4'b1111;
         if (c == 3) mem_rsp_valid = 1'b0;
         @(negedge clk);
         if (c < 2) begin
            n_cmp++; if (core_rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL rs_valid[%0d]: got %b expected 1000", c, core_rsp_valid); end
            n_cmp++; if (mem_rsp_ready !== 1'b0) begin n_bad++; $display("FAIL rs_stall[%0d]: got %b expected 0", c, mem_rsp_ready); end
         end
         if (c == 2) begin
            n_cmp++; if (mem_rsp_ready !== 1'b1) begin n_bad++; $display("FAIL rs_release: got %b expected 1", mem_rsp_ready); end
            n_cmp++; if (core_rsp_tag[3*TW +: TW] !== 8'h77) begin n_bad++; $display("FAIL rs_tag: got %h expected 77", core_rsp_tag[3*TW +: TW]); end
         end
         if (core_rsp_valid[3] && core_rsp_ready[3]) n_xfer++;
         $display("rsp stall cycle %0d: rsp_valid=%b mem_rsp_ready=%b", c, core_rsp_valid, mem_rsp_ready);
         cyc();
      end
      n_cmp++; if (n_xfer !== 1) begin n_bad++; $display("FAIL rs_xfer_count: got %0d expected 1", n_xfer); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rs_no_underflow: got %b expected 0", busy); end
      cyc();
   endtask

   task automatic test_reset_mid();
      logic [3:0] seen;
      do_reset();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 26'(26'h300 + i), 8'(8'hC0 + i), '0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         seen = core_req_ready & core_req_valid;
         cyc();
         core_req_valid = core_req_valid & ~seen;
      end
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rm_buffered: got %b expected 1", mem_req_valid); end
      cyc();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rm_mem_valid_rst: got %b expected 0", mem_req_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy_rst: got %b expected 0", busy); end
      cyc();
      reset = 1'b0;
      core_req_valid = 4'b1111;
      @(negedge clk);
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rm_flushed: got %b expected 0", mem_req_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy_after: got %b expected 0", busy); end
      n_cmp++; if (core_req_ready !== 4'b0001) begin n_bad++; $display("FAIL rm_arb_restart: got %b expected 0001", core_req_ready); end
      $display("reset mid-traffic: ready=%b mem_valid=%b busy=%b", core_req_ready, mem_req_valid, busy);
      cyc();
      core_req_valid = '0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_backpressure();
      test_write();
      test_rsp_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vx_cache_wrap.md
VX_CACHE_WRAP -- requirements
Module: vx_cache_wrap

Interface
REQ-001 The module SHALL have parameters, one per line:
- NUM_REQS, default 4, number of core-side request ports.
- MEM_PORTS, default 1, number of memory-side ports; NUM_REQS SHALL be a multiple of MEM_PORTS.
- LINE_SIZE, default 64, bytes per request.
- ADDR_WIDTH, default 26, line address width.
- TAG_WIDTH, default 8, core tag width.
REQ-002 The module SHALL define these derived widths:
- G = NUM_REQS/MEM_PORTS.
- IW = max(1, clog2(G)).
- MEM_TAG_WIDTH = TAG_WIDTH+IW.
- DW = 8*LINE_SIZE.
REQ-003 The module SHALL have ports, one per line (arrays flattened, port i at slice i):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- core_req_valid  in  NUM_REQS  request valid.
- core_req_rw  in  NUM_REQS  1=write.
- core_req_byteen  in  NUM_REQS*LINE_SIZE  byte enables.
- core_req_addr  in  NUM_REQS*ADDR_WIDTH  line address.
- core_req_data  in  NUM_REQS*DW  write data.
- core_req_tag  in  NUM_REQS*TAG_WIDTH  request tag.
- core_req_ready  out  NUM_REQS  request accepted.
- core_rsp_valid  out  NUM_REQS  response valid.
- core_rsp_data  out  NUM_REQS*DW  read data.
- core_rsp_tag  out  NUM_REQS*TAG_WIDTH  response tag.
- core_rsp_ready  in  NUM_REQS  response accepted.
- mem_req_valid  out  MEM_PORTS  request valid.
- mem_req_rw  out  MEM_PORTS  1=write.
- mem_req_byteen  out  MEM_PORTS*LINE_SIZE  byte enables.
- mem_req_addr  out  MEM_PORTS*ADDR_WIDTH  line address.
- mem_req_data  out  MEM_PORTS*DW  write data.
- mem_req_tag  out  MEM_PORTS*MEM_TAG_WIDTH  request tag.
- mem_req_ready  in  MEM_PORTS  request accepted.
- mem_rsp_valid  in  MEM_PORTS  response valid.
- mem_rsp_data  in  MEM_PORTS*DW  read data.
- mem_rsp_tag  in  MEM_PORTS*MEM_TAG_WIDTH  response tag.
- mem_rsp_ready  out  MEM_PORTS  response accepted.
- busy  out  1  reads outstanding.
REQ-004 The clock SHALL be clk; the reset SHALL be reset, synchronous, active-high.

Function
REQ-005 Core port i SHALL belong to memory port p = i mod MEM_PORTS, with local index k = i / MEM_PORTS.
REQ-006 A transfer SHALL occur on any valid&&ready cycle; a source SHALL hold valid and payload stable until ready, and the block SHALL never drop or duplicate a transfer.
REQ-007 Per memory port, a round-robin arbiter SHALL select one valid core request among its G ports.
- Priority pointer SHALL start at local index 0 after reset.
- After a grant to k, the pointer SHALL move to (k+1) mod G.
- The pointer SHALL not move when no grant occurs.
REQ-008 Only the granted port's core_req_ready SHALL be 1, and only when the port's request buffer can accept.
REQ-009 Each memory port SHALL have a 2-entry elastic (skid) request buffer.
- Granted request appears on mem_req_* the cycle after acceptance (latency 1).
- Full throughput of one request per cycle while mem_req_ready=1.
- Order preserved per port.
REQ-010 The forwarded request SHALL carry rw, byteen, addr and data unchanged, and mem_req_tag = {core tag, k[IW-1:0]}; k=0 when G=1.
REQ-011 Response path SHALL be combinational:
- Tag fields: k' = mem_rsp_tag[IW-1:0]; core tag = upper TAG_WIDTH bits.
- core_rsp_valid[p + k'*MEM_PORTS] = mem_rsp_valid[p].
- core_rsp_data and core_rsp_tag SHALL be driven from that memory response.
- mem_rsp_ready[p] = core_rsp_ready of the selected core port.
REQ-012 Writes SHALL generate no core response; memory SHALL return responses only for reads.
REQ-013 Responses on a port MAY return out of order; routing SHALL depend only on the tag.
REQ-014 A pending-read counter of width clog2(NUM_REQS*4)+1 SHALL track outstanding reads.
- Increment on each mem read request fire; decrement on each mem response fire.
- Simultaneous increment and decrement SHALL leave it unchanged.
- Saturate at its maximum; never underflow below 0.
REQ-015 busy SHALL be 1 when the pending counter is nonzero or any request buffer is non-empty.

Reset
REQ-016 During reset, the following SHALL be 0:
- mem_req_valid, core_req_ready, busy.
- the pending counter and all buffer occupancy.
- every arbiter pointer.
REQ-017 Reset mid-operation SHALL discard all buffered requests and outstanding counts; core_rsp_valid SHALL follow mem_rsp_valid combinationally even during reset.
REQ-018 In-flight responses arriving after reset SHALL be routed per REQ-011 but SHALL not decrement the counter below 0.

Verification
REQ-019 Single read, NUM_REQS=4, MEM_PORTS=1:
- Stimulus: port 2 sends addr 0x100, tag 0x5A.
- mem_req next cycle with tag {0x5A,2'b10}=0x16A; busy=1.
- Memory response with tag 0x16A and data D -> core_rsp_valid[2]=1 with data D, tag 0x5A.
- busy then returns to 0.
REQ-020 Contention: all 4 ports valid continuously with mem_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one mem request per cycle.
REQ-021 Backpressure:
- mem_req_ready=0 for 5 cycles -> at most 2 requests buffered, then core_req_ready=0.
- On release, requests emerge in acceptance order, none lost.
REQ-022 Write: port 1 write, byteen all-ones, data 0xAB.. -> mem_req_rw=1 with identical data; no core response.
REQ-023 Response stall:
- mem_rsp_valid for port 3 while core_rsp_ready[3]=0 -> mem_rsp_ready=0.
- Once core_rsp_ready[3] rises, exactly one transfer occurs.
REQ-024 Reset mid-traffic: assert reset with 2 buffered requests -> next cycle mem_req_valid=0, busy=0, and the arbiter restarts at port 0.
